audio_sample_fifo: RTL and testbench
====================================

// Module: audio_sample_fifo
// PURPOSE
//  Captures stereo samples from the audio_codec read port and acks each one on read.
//  Narrows each 24-bit signed sample to 16 bits and buffers L/R pairs in a sync FIFO.
//  Presents them over a valid/ready handshake to the BCH encoder pipeline.
//  Replaces the free-running shifter sampling, so no sample is duplicated or silently lost.
// PARAMETERS
//  DEPTH   8   FIFO depth in stereo pairs; power of two, >=2
//  IN_W    24  codec sample width
//  OUT_W   16  encoder sample width (IN_W-OUT_W = SHIFT = 8)
// PORTS
//  clk            in   1          system clock (CLOCK_50 domain)
//  reset          in   1          synchronous, active-high
//  read_ready     in   1          codec has a stereo sample
//  read           out  1          ack to codec = read_ready & ~reset (combinational)
//  readdata_left  in   IN_W       codec left sample, signed
//  readdata_right in   IN_W       codec right sample, signed
//  out_valid      out  1          FIFO head valid
//  out_ready      in   1          downstream accepts head this cycle
//  out_left       out  OUT_W      head left sample, signed
//  out_right      out  OUT_W      head right sample, signed
//  count          out  clog2(DEPTH)+1  occupancy in pairs
//  overflow       out  1          sticky: a sample was dropped
//  drop_cnt       out  8          dropped-pair count, saturates at 255
// BEHAVIOUR
//  Reset: read=0, out_valid=0, out_left/right=0, count=0, overflow=0, drop_cnt=0.
//   Pipeline valids and pointers are cleared. Reset mid-transfer discards all buffered data.
//  Codec is always acked: read follows read_ready, so the codec never stalls.
//  S1 capture: on an edge with read_ready=1, latch both samples and set v1.
//  S2 convert: on the next edge, latch the converted pair and set v2.
//  S3 write: on the next edge, write to the FIFO if not full_eff.
//   full_eff = (count==DEPTH) & ~(out_valid&out_ready).
//   Simultaneous push and pop when full: both happen and count is unchanged.
//  Drop: v2 & full_eff discards the pair, sets overflow, and increments drop_cnt (holds at 255).
//  Latency: read_ready in cycle N gives out_valid=1 in cycle N+3 if the FIFO is empty. No bypass.
//  Output is first-word-fall-through. out_left/right show the head while out_valid=1.
//   They hold the last value when the FIFO is empty.
//  Pop: on an edge with out_valid & out_ready. out_ready while out_valid=0 is ignored.
//  Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
//  Conversion (default): out = in >>> SHIFT, arithmetic truncation.
//   0x7FFFFF->0x7FFF, 0xFFFF80->0xFFFF, 0x800000->0x8000.
// CONFIGURATION
//  Macro AUDIO_ROUND_EN:
//   Defined: out = sat16((in + 2^(SHIFT-1)) >>> SHIFT), computed at IN_W+1 bits.
//    Results above 0x7FFF clamp to 0x7FFF. 0xFFFF80 -> 0x0000; 0x7FFFFF -> 0x7FFF; 0x000080 -> 0x0001.
//   Undefined: plain truncation as above, with no added logic.
//   Latency is identical either way.
// STRUCTURE
//  Package audio_pkg:
//   AUD_IN_W=24, AUD_OUT_W=16, AUD_SHIFT=8.
//   typedef stereo16_t {left,right} (OUT_W each); typedef stereo24_t.
//  Sub-module sync_fifo (generic width/depth, FWFT, count output).
//   Instantiated once with width 2*OUT_W.
//  Capture, convert, drop accounting and the ROUND macro live in the top module.
// TESTING
//  1 Reset: hold reset 3 cycles with read_ready=1 -> read=0, out_valid=0, count=0, drop_cnt=0.
//  2 Single pair: L=0x123456, R=0xFEDCBA, one read_ready pulse in cycle N ->
//     out_valid in N+3, out_left=0x1234, out_right=0xFEDC.
//  3 Fill/overflow: DEPTH=8, out_ready=0, 10 pulses -> count=8, drop_cnt=2, overflow=1.
//     Drain gives pairs 1..8 in order.
//  4 Full + simultaneous: count=8 with out_ready=1 and a push in the same edge ->
//     no drop, count stays 8, order is preserved.
//  5 Wrap: 20 pairs streamed with out_ready toggling 1/0 ->
//     all 20 received in order, drop_cnt=0.
//  6 AUDIO_ROUND_EN: inputs 0xFFFF80, 0x7FFFFF, 0x000080 ->
//     0x0000, 0x7FFF, 0x0001. Without the macro -> 0xFFFF, 0x7FFF, 0x0000.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared widths and stereo sample types for the codec-to-encoder audio path.
package audio_pkg;

    localparam int AUD_IN_W  = 24;
    localparam int AUD_OUT_W = 16;
    localparam int AUD_SHIFT = AUD_IN_W - AUD_OUT_W;

    typedef struct packed {
        logic signed [AUD_OUT_W-1:0] left;
        logic signed [AUD_OUT_W-1:0] right;
    } stereo16_t;

    typedef struct packed {
        logic signed [AUD_IN_W-1:0] left;
        logic signed [AUD_IN_W-1:0] right;
    } stereo24_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through sync FIFO. The head is held in a register
// so rdata keeps its last value once the FIFO runs empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop_ready,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    head_idx_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             pop_s;
    logic             push_ok_s;

    // Handshake qualification, next occupancy and next head slot
    always_comb begin
        pop_s        = valid_r && pop_ready;
        push_ok_s    = push && ((count_r != CW'(DEPTH)) || pop_s);
        count_next_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            head_idx_s = rd_ptr_r + AW'(1);
        end else begin
            head_idx_s = rd_ptr_r;
        end
    end

    // Storage array, written without reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            data_r   <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != CW'(0));
            // The slot being written this edge is not yet in mem_r, so forward it
            if (count_next_s != CW'(0)) begin
                if (push_ok_s && (head_idx_s == wr_ptr_r)) begin
                    data_r <= wdata;
                end else begin
                    data_r <= mem_r[head_idx_s];
                end
            end
        end
    end

    assign rdata = data_r;
    assign valid = valid_r;
    assign count = count_r;

endmodule

// File: rtl/audio_sample_fifo.sv
// Codec capture -> 24-to-16 bit narrowing -> FWFT FIFO towards the encoder.
// Define AUDIO_ROUND_EN to round-and-saturate instead of truncating.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IN_W  = AUD_IN_W,
    parameter int OUT_W = AUD_OUT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   read_ready,
    output logic                   read,
    input  logic [IN_W-1:0]        readdata_left,
    input  logic [IN_W-1:0]        readdata_right,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_left,
    output logic [OUT_W-1:0]       out_right,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int SHIFT = IN_W - OUT_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    stereo24_t cap_r;
    stereo16_t conv_r;
    stereo16_t head_s;
    logic      v1_r;
    logic      v2_r;
    logic      full_eff_s;
    logic      push_s;
    logic      drop_s;
    logic      overflow_r;
    logic [7:0] drop_cnt_r;

    function automatic logic [OUT_W-1:0] narrow(input logic signed [IN_W-1:0] s);
`ifdef AUDIO_ROUND_EN
        logic signed [IN_W:0] wide;
        logic signed [IN_W:0] max_v;
        max_v = (IN_W+1)'((2 ** (OUT_W-1)) - 1);
        wide  = {s[IN_W-1], s};
        wide  = wide + (IN_W+1)'(2 ** (SHIFT-1));
        wide  = wide >>> SHIFT;
        if (wide > max_v) begin
            return OUT_W'(max_v);
        end else begin
            return OUT_W'(wide);
        end
`else
        return OUT_W'(s >>> SHIFT);
`endif
    endfunction

    assign read = read_ready & ~reset;

    // The codec is never stalled; a pair that cannot enter the FIFO is dropped
    always_comb begin
        full_eff_s = (count == CW'(DEPTH)) && !(out_valid && out_ready);
        push_s     = v2_r && !full_eff_s;
        drop_s     = v2_r && full_eff_s;
    end

    // Capture and convert stages
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r   <= 1'b0;
            v2_r   <= 1'b0;
            cap_r  <= '0;
            conv_r <= '0;
        end else begin
            v1_r <= read_ready;
            v2_r <= v1_r;
            if (read_ready) begin
                cap_r.left  <= readdata_left;
                cap_r.right <= readdata_right;
            end
            if (v1_r) begin
                conv_r.left  <= narrow(cap_r.left);
                conv_r.right <= narrow(cap_r.right);
            end
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (2*OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .wdata     (conv_r),
        .pop_ready (out_ready),
        .rdata     (head_s),
        .valid     (out_valid),
        .count     (count)
    );

    assign out_left  = head_s.left;
    assign out_right = head_s.right;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: stimulus queues expected pairs,
// a negedge monitor checks every accepted head in order.
`timescale 1ns/1ps
module tb_audio_sample_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_ready;
    logic        read;
    logic [23:0] readdata_left;
    logic [23:0] readdata_right;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

`ifdef AUDIO_ROUND_EN
    localparam logic [15:0] EXP_T2_R = 16'hFEDD;
    localparam logic [15:0] EXP_C1   = 16'h0000;
    localparam logic [15:0] EXP_C3   = 16'h0001;
`else
    localparam logic [15:0] EXP_T2_R = 16'hFEDC;
    localparam logic [15:0] EXP_C1   = 16'hFFFF;
    localparam logic [15:0] EXP_C3   = 16'h0000;
`endif

    always #5 clk = ~clk;

    audio_sample_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .read_ready     (read_ready),
        .read           (read),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_left       (out_left),
        .out_right      (out_right),
        .count          (count),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every head accepted by the downstream must match the scoreboard
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pair_unexpected: got %h expected none", {out_left, out_right});
            end else begin
                check("pair", {out_left, out_right}, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [23:0] l, input logic [23:0] r,
                        input logic [15:0] el, input logic [15:0] er, input bit keep);
        @(posedge clk); #1;
        read_ready     = 1'b1;
        readdata_left  = l;
        readdata_right = r;
        if (keep) exp_q.push_back({el, er});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            read_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        out_ready  = 1'b0;
        read_ready = 1'b0;
        reset      = 1'b1;
        idle(2);
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; read_ready = 1'b1; out_ready = 1'b0;
        readdata_left = 24'h0; readdata_right = 24'h0;

        // 1: reset held with read_ready asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_read", 32'(read), 32'd0);
        check("t1_valid", 32'(out_valid), 32'd0);
        check("t1_count", 32'(count), 32'd0);
        check("t1_drop", 32'(drop_cnt), 32'd0);
        check("t1_ovf", 32'(overflow), 32'd0);
        check("t1_data", {out_left, out_right}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; read_ready = 1'b0;
        idle(2);

        // 2: single pair, three-cycle latency
        out_ready = 1'b1;
        send(24'h123456, 24'hFEDCBA, 16'h1234, EXP_T2_R, 1'b1);
        @(negedge clk);
        check("t2_read", 32'(read), 32'd1);
        check("t2_valid_n", 32'(out_valid), 32'd0);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        check("t2_valid_n2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t2_valid_n3", 32'(out_valid), 32'd1);
        drain(20);
        check("t2_hold", {out_left, out_right}, {16'h1234, EXP_T2_R});

        // reset mid-transfer discards buffered pairs
        out_ready = 1'b0;
        send(24'h010000, 24'h020000, 16'h0100, 16'h0200, 1'b0);
        send(24'h030000, 24'h040000, 16'h0300, 16'h0400, 1'b0);
        idle(4);
        check("mid_count", 32'(count), 32'd2);
        do_reset();

        // 3: fill and overflow
        for (int i = 1; i <= 10; i++) begin
            send(24'(i) << 8, 24'(-(i * 256)), 16'(i), 16'(-i), i <= 8);
        end
        idle(5);
        check("t3_count", 32'(count), 32'd8);
        check("t3_drop", 32'(drop_cnt), 32'd2);
        check("t3_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        drain(40);
        check("t3_empty", 32'(count), 32'd0);
        check("t3_valid", 32'(out_valid), 32'd0);

        // 4: push and pop on the same edge while full
        do_reset();
        for (int i = 11; i <= 18; i++) begin
            send(24'(i) << 8, 24'(-(i * 256)), 16'(i), 16'(-i), 1'b1);
        end
        idle(5);
        check("t4_full", 32'(count), 32'd8);
        send(24'd19 << 8, 24'(-(19 * 256)), 16'd19, 16'(-19), 1'b1);
        idle(1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_count", 32'(count), 32'd8);
        check("t4_drop", 32'(drop_cnt), 32'd0);
        check("t4_ovf", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        drain(40);

        // 5: 20 pairs streamed with out_ready toggling, pointers wrap
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready  = c[0];
            read_ready = !c[0];
            if (!c[0]) begin
                readdata_left  = 24'(100 + c / 2) << 8;
                readdata_right = 24'(-((100 + c / 2) * 256));
                exp_q.push_back({16'(100 + c / 2), 16'(-(100 + c / 2))});
            end
        end
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
            read_ready = 1'b0;
            out_ready  = c[0];
        end
        check("t5_left", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        idle(3);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        check("t5_count", 32'(count), 32'd0);

        // 6: conversion corner values
        do_reset();
        out_ready = 1'b1;
        send(24'hFFFF80, 24'h7FFFFF, EXP_C1, 16'h7FFF, 1'b1);
        send(24'h000080, 24'h800000, EXP_C3, 16'h8000, 1'b1);
        idle(1);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
